updown_mod_counter: RTL and testbench

Parametrised multi-mode counter: up/down, with selectable free-running wrap, programmable modulo, saturating or one-shot behaviour. Supports synchronous load, a one-cycle terminal-count pulse and a divide-by-2-of-terminal-count output. It is the general-purpose timer/counter primitive for timeouts, rate dividers and event counting in the design.

---
 rtl/updown_mod_counter.sv | 126 ++++++++++++
 tb/tb_updown_mod_counter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down counter with wrap, modulo, saturate and one-shot modes
// Registered count, terminal-count pulse, one-shot busy flag and tc-rate divide-by-2 output.
module updown_mod_counter #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_start,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_busy,
  output logic             o_div_out
);

  localparam logic [1:0] MODE_WRAP    = 2'b00;
  localparam logic [1:0] MODE_MODULO  = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b11;
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_div;

  logic [WIDTH-1:0] w_next;
  logic             w_tc;
  logic             w_step;
  logic             w_oneshot;

  assign w_oneshot = (i_mode == MODE_ONESHOT);
  assign w_step    = i_en && (!w_oneshot || (r_state == RUN));

  // Next value and tc flag for a step; only applied when w_step and no load.
  always_comb begin
    w_next = r_count;
    w_tc   = 1'b0;
    case (i_mode)
      MODE_WRAP: begin
        if (i_dir) begin
          w_next = r_count + ONE;
          w_tc   = (r_count == '1);
        end else begin
          w_next = r_count - ONE;
          w_tc   = (r_count == '0);
        end
      end
      MODE_MODULO: begin
        if (i_dir) begin
          if (r_count >= i_limit) begin
            w_next = '0;
            w_tc   = 1'b1;
          end else begin
            w_next = r_count + ONE;
          end
        end else begin
          if (r_count == '0) begin
            w_next = i_limit;
            w_tc   = 1'b1;
          end else begin
            w_next = r_count - ONE;
          end
        end
      end
      default: begin
        // Saturate and one-shot share the step rule; one-shot also fires when already parked.
        if (i_dir) begin
          if (r_count < i_limit) begin
            w_next = r_count + ONE;
            w_tc   = ((r_count + ONE) == i_limit);
          end else begin
            w_tc   = w_oneshot;
          end
        end else begin
          if (r_count != '0) begin
            w_next = r_count - ONE;
            w_tc   = (r_count == ONE);
          end else begin
            w_tc   = w_oneshot;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_tc    <= 1'b0;
      r_div   <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      if (!w_oneshot) begin
        r_state <= IDLE;
      end else if ((r_state == IDLE) && i_start) begin
        r_state <= RUN;
      end else if ((r_state == RUN) && !i_load && w_step && w_tc) begin
        r_state <= IDLE;
      end

      if (i_load) begin
        r_count <= i_load_val;
      end else if (w_step) begin
        r_count <= w_next;
        r_tc    <= w_tc;
        if (w_tc) begin
          r_div <= ~r_div;
        end
      end
    end
  end

  assign o_count   = r_count;
  assign o_tc      = r_tc;
  assign o_busy    = (r_state == RUN);
  assign o_div_out = r_div;

endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed scoreboard bench for updown_mod_counter
module tb_updown_mod_counter;

  logic       clk;
  logic       rst;
  logic       en;
  logic       dir;
  logic [1:0] mode;
  logic [3:0] limit;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic [3:0] count;
  logic       tc;
  logic       busy;
  logic       div_out;

  typedef struct packed {
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       div;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  updown_mod_counter #(.WIDTH(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_dir      (dir),
    .i_mode     (mode),
    .i_limit    (limit),
    .i_load     (load),
    .i_load_val (load_val),
    .i_start    (start),
    .o_count    (count),
    .o_tc       (tc),
    .o_busy     (busy),
    .o_div_out  (div_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [3:0] ec, input logic et, input logic eb,
                      input logic ed, input string tag);
    exp_t e;
    exp_q.push_back({ec, et, eb, ed});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_assert++;
    assert (count === e.count) else begin
      n_fail++;
      $error("FAIL %s count got %0d want %0d", tag, count, e.count);
    end
    n_assert++;
    assert (tc === e.tc) else begin
      n_fail++;
      $error("FAIL %s tc got %0b want %0b", tag, tc, e.tc);
    end
    n_assert++;
    assert (busy === e.busy) else begin
      n_fail++;
      $error("FAIL %s busy got %0b want %0b", tag, busy, e.busy);
    end
    n_assert++;
    assert (div_out === e.div) else begin
      n_fail++;
      $error("FAIL %s div_out got %0b want %0b", tag, div_out, e.div);
    end
    rst   = 1'b0;
    load  = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 1'b1; mode = 2'b00; limit = 4'd0;
    load = 1'b0; load_val = 4'd0; start = 1'b0;
    tick(4'd0, 1'b0, 1'b0, 1'b0, "reset");

    // free wrap, 17 up steps
    mode = 2'b00; dir = 1'b1; en = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      tick(4'(i % 16), (i == 16), 1'b0, (i >= 16), "wrap_up");
    end
    en = 1'b0;
    tick(4'd1, 1'b0, 1'b0, 1'b1, "hold_en0");

    // modulo 9
    mode = 2'b01; limit = 4'd9; load = 1'b1; load_val = 4'd0;
    tick(4'd0, 1'b0, 1'b0, 1'b1, "mod_load0");
    en = 1'b1; dir = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick(4'(i), 1'b0, 1'b0, 1'b1, "mod_up");
    end
    tick(4'd0, 1'b1, 1'b0, 1'b0, "mod_up_wrap");
    dir = 1'b0;
    tick(4'd9, 1'b1, 1'b0, 1'b1, "mod_down_wrap");
    load = 1'b1; load_val = 4'd12;
    tick(4'd12, 1'b0, 1'b0, 1'b1, "mod_load12");
    tick(4'd11, 1'b0, 1'b0, 1'b1, "mod_down_above");

    // saturate 5
    mode = 2'b10; limit = 4'd5; dir = 1'b1; load = 1'b1; load_val = 4'd3;
    tick(4'd3, 1'b0, 1'b0, 1'b1, "sat_load3");
    tick(4'd4, 1'b0, 1'b0, 1'b1, "sat_up4");
    tick(4'd5, 1'b1, 1'b0, 1'b0, "sat_up5");
    tick(4'd5, 1'b0, 1'b0, 1'b0, "sat_hold_a");
    tick(4'd5, 1'b0, 1'b0, 1'b0, "sat_hold_b");
    load = 1'b1; load_val = 4'd1;
    tick(4'd1, 1'b0, 1'b0, 1'b0, "sat_load1");
    dir = 1'b0;
    tick(4'd0, 1'b1, 1'b0, 1'b1, "sat_down0");
    tick(4'd0, 1'b0, 1'b0, 1'b1, "sat_down_hold");

    // one-shot 3
    mode = 2'b11; limit = 4'd3; dir = 1'b1; en = 1'b0; load = 1'b1; load_val = 4'd0;
    tick(4'd0, 1'b0, 1'b0, 1'b1, "os_load0");
    start = 1'b1;
    tick(4'd0, 1'b0, 1'b1, 1'b1, "os_start");
    en = 1'b1;
    tick(4'd1, 1'b0, 1'b1, 1'b1, "os_run1");
    tick(4'd2, 1'b0, 1'b1, 1'b1, "os_run2");
    tick(4'd3, 1'b1, 1'b0, 1'b0, "os_done");
    tick(4'd3, 1'b0, 1'b0, 1'b0, "os_idle_en");
    en = 1'b0; start = 1'b1;
    tick(4'd3, 1'b0, 1'b1, 1'b0, "os_rearm");
    en = 1'b1;
    tick(4'd3, 1'b1, 1'b0, 1'b1, "os_immediate");

    // same-cycle conflicts
    mode = 2'b00; en = 1'b1; dir = 1'b1; load = 1'b1; load_val = 4'd7;
    tick(4'd7, 1'b0, 1'b0, 1'b1, "load_over_step");
    rst = 1'b1; load = 1'b1; load_val = 4'd9;
    tick(4'd0, 1'b0, 1'b0, 1'b0, "rst_over_load");
    mode = 2'b11; limit = 4'd3; en = 1'b0; load = 1'b1; load_val = 4'd2; start = 1'b1;
    tick(4'd2, 1'b0, 1'b1, 1'b0, "start_with_load");
    rst = 1'b1;
    tick(4'd0, 1'b0, 1'b0, 1'b0, "rst_in_run");
    en = 1'b1;
    tick(4'd0, 1'b0, 1'b0, 1'b0, "en_no_start");

    // leaving one-shot mode drops busy
    en = 1'b0; start = 1'b1;
    tick(4'd0, 1'b0, 1'b1, 1'b0, "os_start2");
    mode = 2'b00;
    tick(4'd0, 1'b0, 1'b0, 1'b0, "mode_exit");

    // modulo with limit 0: back-to-back tc
    mode = 2'b01; limit = 4'd0; dir = 1'b1; en = 1'b1;
    tick(4'd0, 1'b1, 1'b0, 1'b1, "lim0_a");
    tick(4'd0, 1'b1, 1'b0, 1'b0, "lim0_b");

    // free wrap down from 0
    mode = 2'b00; dir = 1'b0;
    tick(4'd15, 1'b1, 1'b0, 1'b1, "wrap_down");
    tick(4'd14, 1'b0, 1'b0, 1'b1, "wrap_down2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
